// File: rtl/vx_matrix_sched.sv
// Shared matrix micro-op sequencer: round-robin grant of one issue slot, expanded into its micro-op stream.
// Optional back-to-back re-arbitration on the last handshake: define MATRIX_SCHED_B2B_EN.
module vx_matrix_sched #(
   parameter  int NUM_REQS = 4,
   parameter  int NR_W     = 6,
   localparam int SEL_W    = $clog2(NUM_REQS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQS-1:0]      req_valid,
   input  logic [NUM_REQS*2-1:0]    req_kind,
   input  logic [NUM_REQS*4-1:0]    req_row_size,
   input  logic [NUM_REQS*NR_W-1:0] req_rd,
   input  logic [NUM_REQS*NR_W-1:0] req_rs1,
   input  logic [NUM_REQS*NR_W-1:0] req_rs2,
   output logic [NUM_REQS-1:0]      req_ready,
   output logic                     uop_valid,
   input  logic                     uop_ready,
   output logic [SEL_W-1:0]         uop_sel,
   output logic [3:0]               uop_idx,
   output logic [NR_W-1:0]          uop_rd,
   output logic [NR_W-1:0]          uop_rs1,
   output logic [NR_W-1:0]          uop_rs2,
   output logic [2:0]               uop_op_mod,
   output logic                     uop_last,
   output logic                     busy
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            r_state;
   logic [SEL_W-1:0]  r_sel;
   logic [SEL_W-1:0]  r_lastGrant;
   logic [3:0]        r_idx;

   logic [1:0]        w_kind;
   logic [3:0]        w_row;
   logic [NR_W-1:0]   w_baseRd;
   logic [NR_W-1:0]   w_baseRs1;
   logic [NR_W-1:0]   w_baseRs2;
   logic [NR_W-1:0]   w_rd;
   logic [NR_W-1:0]   w_rs1;
   logic [NR_W-1:0]   w_rs2;
   logic [2:0]        w_opMod;
   logic [3:0]        w_lastIdx;
   logic [NR_W-1:0]   w_idxExt;
   logic [NUM_REQS-1:0] w_selOh;
   logic              w_issue;
   logic              w_reqValidSel;
   logic              w_hs;
   logic              w_last;
   logic              w_lastHs;
   logic [SEL_W:0]    w_idlePick;

   // Returns {found, slot}; search begins at base+1 and wraps.
   function automatic logic [SEL_W:0] rrPick(input logic [NUM_REQS-1:0] reqs,
                                             input logic [SEL_W-1:0]    base);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] cand;
      res = '0;
      for (int i = 1; i <= NUM_REQS; i++) begin
         cand = SEL_W'((int'(base) + i) % NUM_REQS);
         if (!res[SEL_W] && reqs[cand]) res = {1'b1, cand};
      end
      return res;
   endfunction

   always_comb begin
      w_kind    = '0;
      w_row     = '0;
      w_baseRd  = '0;
      w_baseRs1 = '0;
      w_baseRs2 = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (r_sel == SEL_W'(i)) begin
            w_kind    = req_kind[i*2 +: 2];
            w_row     = req_row_size[i*4 +: 4];
            w_baseRd  = req_rd[i*NR_W +: NR_W];
            w_baseRs1 = req_rs1[i*NR_W +: NR_W];
            w_baseRs2 = req_rs2[i*NR_W +: NR_W];
         end
      end
   end

   assign w_idxExt = NR_W'(r_idx);

   always_comb begin
      w_rd      = w_baseRd;
      w_rs1     = w_baseRs1;
      w_rs2     = w_baseRs2;
      w_opMod   = 3'b000;
      w_lastIdx = 4'd0;
      case (w_kind)
         2'b01: begin
            w_rd      = w_baseRd + w_idxExt;
            w_lastIdx = (w_row == 4'd0) ? 4'd0 : w_row - 4'd1;
         end
         2'b10: begin
            if (r_idx == 4'd0) begin
               w_rd = w_baseRs1;
            end else if (r_idx == 4'd1) begin
               w_rd  = w_baseRs2;
               w_rs1 = w_baseRs1 + NR_W'(1);
               w_rs2 = w_baseRs2 + NR_W'(1);
            end
            w_opMod   = (r_idx < w_row) ? 3'b010 : 3'b000;
            w_lastIdx = w_row;
         end
         default: begin
            w_lastIdx = 4'd0;
         end
      endcase
   end

   assign w_issue       = (r_state == ISSUE);
   assign w_reqValidSel = req_valid[r_sel];
   assign w_last        = (r_idx == w_lastIdx);
   assign w_hs          = uop_valid && uop_ready;
   assign w_lastHs      = w_hs && w_last;
   assign w_selOh       = NUM_REQS'(1) << r_sel;
   assign w_idlePick    = rrPick(req_valid, r_lastGrant);

`ifdef MATRIX_SCHED_B2B_EN
   // The finishing slot is masked so its still-asserted request cannot win again immediately.
   logic [SEL_W:0] w_b2bPick;
   assign w_b2bPick = rrPick(req_valid & ~w_selOh, r_sel);
`endif

   assign uop_valid  = w_issue && w_reqValidSel;
   assign uop_sel    = r_sel;
   assign uop_idx    = r_idx;
   assign uop_rd     = w_issue ? w_rd : '0;
   assign uop_rs1    = w_issue ? w_rs1 : '0;
   assign uop_rs2    = w_issue ? w_rs2 : '0;
   assign uop_op_mod = w_issue ? w_opMod : 3'b000;
   assign uop_last   = w_issue && w_last;
   assign busy       = w_issue;
   assign req_ready  = w_lastHs ? w_selOh : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_sel       <= '0;
         r_idx       <= '0;
         r_lastGrant <= SEL_W'(NUM_REQS - 1);
      end else begin
         case (r_state)
            IDLE: begin
               if (w_idlePick[SEL_W]) begin
                  r_sel   <= w_idlePick[SEL_W-1:0];
                  r_idx   <= '0;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (!w_reqValidSel) begin
                  r_state <= IDLE;
                  r_idx   <= '0;
               end else if (w_hs) begin
                  if (w_last) begin
                     r_lastGrant <= r_sel;
                     r_idx       <= '0;
`ifdef MATRIX_SCHED_B2B_EN
                     if (w_b2bPick[SEL_W]) r_sel <= w_b2bPick[SEL_W-1:0];
                     else                  r_state <= IDLE;
`else
                     r_state <= IDLE;
`endif
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vx_matrix_sched.sv
// Scoreboard bench for vx_matrix_sched: stimulus pushes expected micro-ops, a monitor pops them on each handshake.
module tb_vx_matrix_sched;

   localparam int NUM_REQS = 4;
   localparam int NR_W     = 6;
`ifdef MATRIX_SCHED_B2B_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 2;
`endif

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] idx;
      logic [5:0] rd;
      logic [5:0] rs1;
      logic [5:0] rs2;
      logic [2:0] op;
      logic       last;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_REQS-1:0]      req_valid;
   logic [NUM_REQS*2-1:0]    req_kind;
   logic [NUM_REQS*4-1:0]    req_row_size;
   logic [NUM_REQS*NR_W-1:0] req_rd;
   logic [NUM_REQS*NR_W-1:0] req_rs1;
   logic [NUM_REQS*NR_W-1:0] req_rs2;
   logic [NUM_REQS-1:0]      req_ready;
   logic                     uop_valid;
   logic                     uop_ready;
   logic [1:0]               uop_sel;
   logic [3:0]               uop_idx;
   logic [NR_W-1:0]          uop_rd;
   logic [NR_W-1:0]          uop_rs1;
   logic [NR_W-1:0]          uop_rs2;
   logic [2:0]               uop_op_mod;
   logic                     uop_last;
   logic                     busy;

   exp_t expQ[$];
   exp_t monExp;
   int   nChecks = 0;
   int   nFails  = 0;
   int   cyc     = 0;
   int   stamps[4];

   vx_matrix_sched #(.NUM_REQS(NUM_REQS), .NR_W(NR_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_kind(req_kind), .req_row_size(req_row_size),
      .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_ready(req_ready),
      .uop_valid(uop_valid), .uop_ready(uop_ready),
      .uop_sel(uop_sel), .uop_idx(uop_idx),
      .uop_rd(uop_rd), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2),
      .uop_op_mod(uop_op_mod), .uop_last(uop_last), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input int act, input int expv);
      nChecks++;
      if (act != expv) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic applyStimulus(input int s, input logic v, input logic [1:0] k, input logic [3:0] row,
                                input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] rs2);
      req_valid[s]              = v;
      req_kind[s*2 +: 2]        = k;
      req_row_size[s*4 +: 4]    = row;
      req_rd[s*NR_W +: NR_W]    = rd;
      req_rs1[s*NR_W +: NR_W]   = rs1;
      req_rs2[s*NR_W +: NR_W]   = rs2;
   endtask

   task automatic pushExp(input int sel, input int idx, input int rd, input int rs1, input int rs2,
                          input int op, input int last);
      exp_t e;
      e.sel  = 2'(sel);
      e.idx  = 4'(idx);
      e.rd   = 6'(rd);
      e.rs1  = 6'(rs1);
      e.rs2  = 6'(rs2);
      e.op   = 3'(op);
      e.last = 1'(last);
      expQ.push_back(e);
   endtask

   task automatic nextDrive();
      @(posedge clk);
      #1;
   endtask

   task automatic waitIdx(input int idx);
      bit found = 0;
      for (int t = 0; t < 200 && !found; t++) begin
         @(negedge clk);
         if (uop_valid && int'(uop_idx) == idx) found = 1;
      end
      if (!found) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL wait_idx: got no valid uop, expected idx %0d", idx);
      end
   endtask

   task automatic waitPulses(input int n);
      int got = 0;
      for (int t = 0; t < 400 && got < n; t++) begin
         @(negedge clk);
         if (|req_ready) begin
            stamps[got] = cyc;
            got++;
         end
      end
      if (got < n) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL wait_ready: got %0d pulses, expected %0d", got, n);
      end
   endtask

   // Monitor: every accepted micro-op must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset && uop_valid && uop_ready) begin
         if (expQ.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL unexpected_uop: got sel %0d idx %0d, expected none", uop_sel, uop_idx);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("uop_sel",    int'(uop_sel),    int'(monExp.sel));
            checkOutput("uop_idx",    int'(uop_idx),    int'(monExp.idx));
            checkOutput("uop_rd",     int'(uop_rd),     int'(monExp.rd));
            checkOutput("uop_rs1",    int'(uop_rs1),    int'(monExp.rs1));
            checkOutput("uop_rs2",    int'(uop_rs2),    int'(monExp.rs2));
            checkOutput("uop_op_mod", int'(uop_op_mod), int'(monExp.op));
            checkOutput("uop_last",   int'(uop_last),   int'(monExp.last));
            checkOutput("req_ready",  int'(req_ready),
                        monExp.last ? (1 << int'(monExp.sel)) : 0);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset        = 1'b0;
      req_valid    = '0;
      req_kind     = '0;
      req_row_size = '0;
      req_rd       = '0;
      req_rs1      = '0;
      req_rs2      = '0;
      uop_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", int'(uop_valid), 0);
      checkOutput("reset_busy",  int'(busy),      0);
      checkOutput("reset_sel",   int'(uop_sel),   0);
      checkOutput("reset_idx",   int'(uop_idx),   0);
      checkOutput("reset_rd",    int'(uop_rd),    0);
      checkOutput("reset_last",  int'(uop_last),  0);
      checkOutput("reset_ready", int'(req_ready), 0);
      reset = 1'b1;

      // MLOAD slot 0, row 4, rd 8
      nextDrive();
      applyStimulus(0, 1'b1, 2'b01, 4'd4, 6'd8, 6'd3, 6'd4);
      for (int k = 0; k < 4; k++) pushExp(0, k, 8 + k, 3, 4, 0, (k == 3) ? 1 : 0);
      @(negedge clk);
      checkOutput("latency_idle",  int'(uop_valid), 0);
      @(negedge clk);
      checkOutput("latency_valid", int'(uop_valid), 1);
      waitPulses(1);
      nextDrive();
      req_valid[0] = 1'b0;

      // MMUL slot 1, row 2
      applyStimulus(1, 1'b1, 2'b10, 4'd2, 6'd5, 6'd10, 6'd20);
      pushExp(1, 0, 10, 10, 20, 2, 0);
      pushExp(1, 1, 20, 11, 21, 2, 0);
      pushExp(1, 2, 5,  10, 20, 0, 1);
      waitPulses(1);
      nextDrive();
      req_valid[1] = 1'b0;

      // MLOAD slot 3 with rd wrapping past 63
      applyStimulus(3, 1'b1, 2'b01, 4'd3, 6'd62, 6'd1, 6'd2);
      pushExp(3, 0, 62, 1, 2, 0, 0);
      pushExp(3, 1, 63, 1, 2, 0, 0);
      pushExp(3, 2, 0,  1, 2, 0, 1);
      waitPulses(1);
      nextDrive();
      req_valid[3] = 1'b0;

      // Round robin between slots 0 (single) and 2 (kind 11)
      applyStimulus(0, 1'b1, 2'b00, 4'd0, 6'd1, 6'd2, 6'd3);
      applyStimulus(2, 1'b1, 2'b11, 4'd9, 6'd4, 6'd5, 6'd6);
      for (int r = 0; r < 2; r++) begin
         pushExp(0, 0, 1, 2, 3, 0, 1);
         pushExp(2, 0, 4, 5, 6, 0, 1);
      end
      waitPulses(4);
      nextDrive();
      req_valid[0] = 1'b0;
      req_valid[2] = 1'b0;
      for (int g = 1; g < 4; g++) checkOutput("rr_gap", stamps[g] - stamps[g-1], GAP);

      // Stall at idx 1 of MLOAD row 3
      applyStimulus(1, 1'b1, 2'b01, 4'd3, 6'd12, 6'd0, 6'd0);
      pushExp(1, 0, 12, 0, 0, 0, 0);
      pushExp(1, 1, 13, 0, 0, 0, 0);
      pushExp(1, 2, 14, 0, 0, 0, 1);
      waitIdx(0);
      nextDrive();
      uop_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("stall_idx",   int'(uop_idx),   1);
         checkOutput("stall_rd",    int'(uop_rd),    13);
         checkOutput("stall_ready", int'(req_ready), 0);
      end
      nextDrive();
      uop_ready = 1'b1;
      waitPulses(1);
      nextDrive();
      req_valid[1] = 1'b0;

      // Abort MMUL row 3 at idx 2, then restart from idx 0
      applyStimulus(2, 1'b1, 2'b10, 4'd3, 6'd30, 6'd40, 6'd50);
      pushExp(2, 0, 40, 40, 50, 2, 0);
      pushExp(2, 1, 50, 41, 51, 2, 0);
      waitIdx(1);
      nextDrive();
      req_valid[2] = 1'b0;
      @(negedge clk);
      checkOutput("abort_valid", int'(uop_valid), 0);
      checkOutput("abort_ready", int'(req_ready), 0);
      @(negedge clk);
      checkOutput("abort_busy",  int'(busy),      0);
      nextDrive();
      req_valid[2] = 1'b1;
      pushExp(2, 0, 40, 40, 50, 2, 0);
      pushExp(2, 1, 50, 41, 51, 2, 0);
      pushExp(2, 2, 30, 40, 50, 2, 0);
      pushExp(2, 3, 30, 40, 50, 0, 1);
      waitPulses(1);
      nextDrive();
      req_valid[2] = 1'b0;

      // Reset mid-MLOAD, then slot 0 must win over slot 3
      applyStimulus(0, 1'b1, 2'b01, 4'd4, 6'd8, 6'd3, 6'd4);
      pushExp(0, 0, 8, 3, 4, 0, 0);
      pushExp(0, 1, 9, 3, 4, 0, 0);
      waitIdx(1);
      nextDrive();
      reset = 1'b0;
      #1;
      checkOutput("midrst_valid", int'(uop_valid), 0);
      checkOutput("midrst_busy",  int'(busy),      0);
      checkOutput("midrst_idx",   int'(uop_idx),   0);
      checkOutput("midrst_rd",    int'(uop_rd),    0);
      checkOutput("midrst_ready", int'(req_ready), 0);
      applyStimulus(0, 1'b1, 2'b00, 4'd0, 6'd1, 6'd2, 6'd3);
      applyStimulus(3, 1'b1, 2'b01, 4'd0, 6'd7, 6'd8, 6'd9);
      pushExp(0, 0, 1, 2, 3, 0, 1);
      pushExp(3, 0, 7, 8, 9, 0, 1);
      nextDrive();
      reset = 1'b1;
      waitPulses(2);
      nextDrive();
      req_valid[0] = 1'b0;
      req_valid[3] = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("queue_empty", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/vx_matrix_sched.md
# vx_matrix_sched

Shared matrix micro-op sequencer for the issue stage. It arbitrates among `NUM_REQS` issue slots that each hold a pending matrix instruction (MLOAD A/B, MMUL, or single-op). It grants one slot at a time and expands the granted instruction into its micro-op stream, one micro-op per accepted handshake, toward the instruction buffers. This lets one expansion counter/FSM be shared instead of replicated per issue slot.

## Interface
- `NUM_REQS`, 4: number of requesting issue slots (≥2).
- `NR_W`, 6: register index width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQS`: slot i holds a pending instruction; fields must be stable while asserted.
- `req_kind` in `NUM_REQS`×2: 00 single, 01 MLOAD A/B, 10 MMUL, 11 treated as single.
- `req_row_size` in `NUM_REQS`×4: matrix row count.
- `req_rd`, `req_rs1`, `req_rs2` in `NUM_REQS`×`NR_W`: base register indices.
- `req_ready` out `NUM_REQS`: one-cycle pulse on the handshake of slot i's last micro-op.
- `uop_valid` out 1: micro-op present.
- `uop_ready` in 1: downstream accepts.
- `uop_sel` out clog2(`NUM_REQS`): granted slot.
- `uop_idx` out 4: micro-op index within the sequence.
- `uop_rd`, `uop_rs1`, `uop_rs2` out `NR_W`: expanded register indices.
- `uop_op_mod` out 3: expanded op modifier.
- `uop_last` out 1: final micro-op of the sequence.
- `busy` out 1: state is ISSUE.

## Operation
- Sequence length N:
  - single: 1.
  - MLOAD: max(row_size, 1).
  - MMUL: row_size+1. Row size 15 gives N=16, so the index never exceeds 15.
- MLOAD micro-op k:
  - rd=req_rd+k, with k zero-extended and the sum truncated to `NR_W`.
  - rs1 and rs2 unchanged.
  - op_mod=000.
- MMUL micro-op k:
  - k=0: rd=rs1, rs1=rs1, rs2=rs2.
  - k=1: rd=rs2, rs1=rs1+1, rs2=rs2+1.
  - k≥2: rd, rs1 and rs2 unchanged.
  - op_mod=010 when k<row_size, else 000.
- Single: all fields pass through; op_mod=000.
- FSM states are IDLE and ISSUE.
- IDLE:
  - `uop_valid`=0.
  - If any `req_valid` is set, the round-robin winner is registered into `sel`, `idx` is set to 0, and the FSM goes to ISSUE.
  - Round-robin search starts at `last_grant`+1 and wraps.
- ISSUE:
  - `uop_valid`=`req_valid[sel]`.
  - Outputs are combinational from registered `sel`/`idx` and the slot's request fields.
  - `uop_last`=(`idx`==N−1).
- Handshake is `uop_valid && uop_ready`:
  - Not last: `idx`+1.
  - Last: pulse `req_ready[sel]`, `last_grant`←`sel`, `idx`←0, next state per Configuration.
- Stall: while `uop_ready`=0, `idx`, `sel` and all outputs hold.
- Abort: if `req_valid[sel]` drops in ISSUE, the FSM goes to IDLE next cycle with `idx`←0, no `req_ready` pulse, and `last_grant` unchanged.
- A `req_valid` on a non-granted slot has no effect until that slot wins arbitration.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE; `idx`=0; `sel`=0.
  - `last_grant`=`NUM_REQS`−1, so slot 0 has first priority.
  - All outputs 0.
- Latency: `req_valid` rising in IDLE gives `uop_valid` on the next cycle.
- Throughput in ISSUE: one micro-op per cycle while `uop_ready`=1.
- `req_ready` is combinational from the last handshake, the same cycle.
- Reset asserted mid-sequence: outputs drop immediately and the partial sequence is discarded.

## Configuration
- `MATRIX_SCHED_B2B_EN` defined:
  - On the last handshake the FSM arbitrates in the same cycle, excluding the just-finished slot's current request.
  - If there is a winner, it stays in ISSUE with the new `sel` and `idx`=0. The next micro-op appears the following cycle, with no bubble.
  - Otherwise it goes to IDLE.
- Not defined: the FSM always returns to IDLE after the last handshake. This gives one bubble cycle between sequences.

## Test plan
- MLOAD on slot 0, row_size=4, rd=8, `uop_ready`=1 → 4 micro-ops: rd 8,9,10,11; idx 0–3; `uop_last` and `req_ready[0]` on the 4th.
- MMUL on slot 1, row_size=2, rd=5, rs1=10, rs2=20 → three micro-ops as (rd,rs1,rs2,op_mod): (10,10,20,010), (20,11,21,010), (5,10,20,000). `req_ready[1]` pulses on the third.
- Slots 0 and 2 held valid with single kind → grant order 0,2,0,2. Gap between grants is 1 idle cycle without the macro and 0 with it.
- MLOAD row_size=3, `uop_ready` low for 3 cycles at idx=1 → `uop_idx`=1 and `uop_rd` held, no advance, `req_ready`=0.
- MMUL row_size=3; drop `req_valid[sel]` at idx=2 → `uop_valid`=0; IDLE next cycle; no `req_ready`; the next grant restarts at idx 0.
- Assert `reset` low at idx=2 of MLOAD → `uop_valid`=0 immediately. After release, slots 0 and 3 both valid → slot 0 granted first.
